// File: rtl/hilo_div_ctrl_if.sv
// Signal bundle joining main control, hilo_div_ctrl and the iterative signed divider.
// slave: the sequencer itself; master: the control/divider side that surrounds it.
interface hilo_div_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              div_req;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              mt_hi;
    logic              mt_lo;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] div_a;
    logic [DATA_W-1:0] div_b;
    logic              div_go;
    logic              div_rst;
    logic [DATA_W-1:0] div_lo;
    logic [DATA_W-1:0] div_hi;
    logic              div_end;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              busy;
    logic              done;
    logic              div_zero_exc;

    modport master (
        output div_req, op_a, op_b, mt_hi, mt_lo, wdata, div_lo, div_hi, div_end,
        input  div_a, div_b, div_go, div_rst, hi, lo, busy, done, div_zero_exc
    );

    modport slave (
        input  div_req, op_a, op_b, mt_hi, mt_lo, wdata, div_lo, div_hi, div_end,
        output div_a, div_b, div_go, div_rst, hi, lo, busy, done, div_zero_exc
    );
endinterface

// File: rtl/hilo_div_ctrl.sv
// HI/LO sequencer around an iterative signed divider: launch/arm/wait handshake, commit, MT/MF access.
// Optional WAIT watchdog is built only when HILO_DIV_TIMEOUT_EN is defined.
module hilo_div_ctrl #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic           clock,
    input  logic           reset,
    hilo_div_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        ST_CLR    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_ARM    = 3'd3,
        ST_WAIT   = 3'd4,
        ST_COMMIT = 3'd5,
        ST_EXC    = 3'd6
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              arm_seen_r;
    logic              timeout_s;
    logic              req_zero_s;
    logic              busy_s;
    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;
    logic [DATA_W-1:0] div_a_r;
    logic [DATA_W-1:0] div_b_r;
    logic              busy_r;
    logic              done_r;
    logic              exc_r;
    logic              go_r;
    logic              div_rst_r;

    if (TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("hilo_div_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    assign req_zero_s = (bus.op_b == {DATA_W{1'b0}});

`ifdef HILO_DIV_TIMEOUT_EN
    localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt_r;

    // Count consecutive WAIT cycles; cleared whenever WAIT is left.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if ((state_r == ST_WAIT) && (state_s == ST_WAIT)) begin
            wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end
    end

    assign timeout_s = (state_r == ST_WAIT) && (wait_cnt_r == WAIT_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state logic of the sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_CLR: begin
                state_s = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.div_req) begin
                    if (req_zero_s) begin
                        state_s = ST_EXC;
                    end else begin
                        state_s = ST_LAUNCH;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_s = ST_ARM;
            end
            ST_ARM: begin
                // div_end is still high from the divider's idle state; give it two cycles to drop.
                if (!bus.div_end) begin
                    state_s = ST_WAIT;
                end else if (arm_seen_r) begin
                    state_s = ST_EXC;
                end else begin
                    state_s = ST_ARM;
                end
            end
            ST_WAIT: begin
                if (bus.div_end) begin
                    state_s = ST_COMMIT;
                end else if (timeout_s) begin
                    state_s = ST_EXC;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_COMMIT: begin
                state_s = ST_IDLE;
            end
            ST_EXC: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_CLR;
            end
        endcase
    end

    // Busy spans LAUNCH through COMMIT of the state about to be entered.
    always_comb begin
        busy_s = 1'b0;
        case (state_s)
            ST_LAUNCH, ST_ARM, ST_WAIT, ST_COMMIT: busy_s = 1'b1;
            default:                               busy_s = 1'b0;
        endcase
    end

    // State register and ARM-cycle marker.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_CLR;
            arm_seen_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            arm_seen_r <= (state_r == ST_ARM);
        end
    end

    // Registered control outputs, decoded from the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            exc_r     <= 1'b0;
            go_r      <= 1'b0;
            div_rst_r <= 1'b1;
        end else begin
            busy_r    <= busy_s;
            done_r    <= (state_s == ST_COMMIT);
            exc_r     <= (state_s == ST_EXC);
            go_r      <= (state_s == ST_LAUNCH);
            div_rst_r <= (state_s == ST_CLR) || (state_s == ST_EXC);
        end
    end

    // Operand capture for the divider on an accepted non-zero request.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_a_r <= {DATA_W{1'b0}};
            div_b_r <= {DATA_W{1'b0}};
        end else if ((state_r == ST_IDLE) && (state_s == ST_LAUNCH)) begin
            div_a_r <= bus.op_a;
            div_b_r <= bus.op_b;
        end
    end

    // HI/LO are loaded on entry to COMMIT so the result is visible together with done.
    always_ff @(posedge clock) begin
        if (reset) begin
            hi_r <= {DATA_W{1'b0}};
            lo_r <= {DATA_W{1'b0}};
        end else if (state_s == ST_COMMIT) begin
            hi_r <= bus.div_hi;
            lo_r <= bus.div_lo;
        end else if (!busy_r) begin
            if (bus.mt_hi) begin
                hi_r <= bus.wdata;
            end
            if (bus.mt_lo) begin
                lo_r <= bus.wdata;
            end
        end
    end

    assign bus.hi           = hi_r;
    assign bus.lo           = lo_r;
    assign bus.div_a        = div_a_r;
    assign bus.div_b        = div_b_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.div_zero_exc = exc_r;
    assign bus.div_go       = go_r;
    assign bus.div_rst      = div_rst_r;
endmodule
